// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative RV32M divider for the EX stage (DIV, DIVU, REM, REMU), radix-2
// restoring. A normal division takes 34 cycles from an accepted start to the
// done pulse. Divide-by-zero and signed overflow finish in one cycle.
//
// Ports
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   start   in   1   request, sampled only in IDLE or DONE
//   divSel  in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   data1   in   32  dividend (rs1)
//   data2   in   32  divisor (rs2)
//   flush   in   1   synchronous abort; wins over start
//   busy    out  1   division in progress (PREP or CALC)
//   done    out  1   one-cycle completion pulse, result valid
//   result  out  32  quotient or remainder, held until next completion
// -----------------------------------------------------------------------------
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  divSel,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_DONE
   } state_t;

   state_t      state, state_next;

   // Captured operation
   logic [31:0] op_a, op_b;
   logic [1:0]  op_sel;

   // Iteration datapath
   logic [63:0] rem_q;      // {partial remainder, quotient being shifted in}
   logic [31:0] divisor;
   logic        neg_q, neg_r;
   logic [4:0]  count;

   // Combinational helpers
   logic        accept;
   logic        special;
   logic [31:0] special_val;
   logic        load_special;
   logic        calc_last;
   logic        op_signed;
   logic [31:0] abs_a, abs_b;
   logic [64:0] shifted;
   logic [33:0] trial;
   logic [63:0] rem_step;
   logic [31:0] quo, rmd, final_val;

   // ------------------------------------------------------------------
   // Start decode and one-cycle special cases (decoded from live inputs)
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // can leave it unassigned and infer a latch.
      accept      = 1'b0;
      special     = 1'b0;
      special_val = 32'h0;
      if ((state == S_IDLE || state == S_DONE) && start && !flush)
         accept = 1'b1;
      if (data2 == 32'h0) begin
         special     = 1'b1;
         special_val = divSel[1] ? data1 : 32'hFFFF_FFFF;
      end else if (!divSel[0] && data1 == 32'h8000_0000 && data2 == 32'hFFFF_FFFF) begin
         special     = 1'b1;
         special_val = divSel[1] ? 32'h0 : 32'h8000_0000;
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // ------------------------------------------------------------------
   // FSM: next state and load strobes
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      load_special = 1'b0;
      calc_last    = 1'b0;
      if (flush) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (special) begin
                     state_next   = S_DONE;
                     load_special = 1'b1;
                  end else begin
                     state_next = S_PREP;
                  end
               end else begin
                  state_next = S_IDLE;
               end
            end
            S_PREP: state_next = S_CALC;
            S_CALC: begin
               if (count == 5'd31) begin
                  state_next = S_DONE;
                  calc_last  = 1'b1;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Datapath combinational: absolute values and one restoring step
   // ------------------------------------------------------------------
   always_comb begin
      op_signed = ~op_sel[0];
      // abs(0x80000000) stays 0x80000000, which is 2^31 read as unsigned.
      abs_a = (op_signed && op_a[31]) ? (32'h0 - op_a) : op_a;
      abs_b = (op_signed && op_b[31]) ? (32'h0 - op_b) : op_b;

      // The shifted partial remainder can need 33 bits, so keep the carry.
      shifted = {rem_q, 1'b0};
      trial   = {1'b0, shifted[64:32]} - {2'b00, divisor};
      if (!trial[33])
         rem_step = {trial[31:0], shifted[31:1], 1'b1};
      else
         rem_step = shifted[63:0];

      quo = rem_step[31:0];
      rmd = rem_step[63:32];
      if (op_sel[1])
         final_val = neg_r ? (32'h0 - rmd) : rmd;
      else
         final_val = neg_q ? (32'h0 - quo) : quo;
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a    <= 32'h0;
         op_b    <= 32'h0;
         op_sel  <= 2'b00;
         rem_q   <= 64'h0;
         divisor <= 32'h0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         count   <= 5'd0;
         result  <= 32'h0;
      end else begin
         if (accept) begin
            op_a   <= data1;
            op_b   <= data2;
            op_sel <= divSel;
         end
         if (state == S_PREP) begin
            rem_q   <= {32'h0, abs_a};
            divisor <= abs_b;
            neg_q   <= op_signed & (op_a[31] ^ op_b[31]);
            neg_r   <= op_signed & op_a[31];
            count   <= 5'd0;
         end else if (state == S_CALC) begin
            rem_q <= rem_step;
            count <= count + 5'd1;
         end
         // result only moves on the edge into DONE; a flush gates both strobes.
         if (load_special)
            result <= special_val;
         else if (calc_last)
            result <= final_val;
      end
   end

   assign busy = (state == S_PREP) || (state == S_CALC);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed and randomized bench for div_unit. Expected results come from a
// plain-arithmetic model of RV32M division; latency is 1 for the special
// cases and 34 otherwise.
// -----------------------------------------------------------------------------
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  divSel;
   logic [31:0] data1;
   logic [31:0] data2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_result;

   div_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .divSel (divSel),
      .data1  (data1),
      .data2  (data2),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // RV32M semantics straight from the arithmetic definition.
   function automatic logic [31:0] ref_model(input logic [1:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 32'h0)
         return sel[1] ? a : 32'hFFFF_FFFF;
      if (!sel[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;   // -2^31 / -1 = 2^31, low word 0x80000000
         r  = sa % sb;
         return sel[1] ? r[31:0] : q[31:0];
      end
      uq = a / b;
      ur = a % b;
      return sel[1] ? ur : uq;
   endfunction

   function automatic bit is_special(input logic [1:0] sel, input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'h0) || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Launch an operation now (caller is mid-cycle) and follow it to done.
   task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      logic [31:0] exp;
      int lat, cyc;
      bit seen, busy_ok;
      exp = ref_model(sel, a, b);
      lat = is_special(sel, a, b) ? 1 : 34;
      start = 1'b1; divSel = sel; data1 = a; data2 = b;
      cyc = 0; seen = 0; busy_ok = 1;
      while (!seen && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            // Operands must have been captured; scramble the live inputs.
            start  = 1'b0;
            data1  = $urandom;
            data2  = $urandom;
            divSel = 2'($urandom);
         end
         if (done) seen = 1;
         else if (busy !== 1'b1) busy_ok = 0;
      end
      check(32'(cyc), 32'(lat), {tag, " latency"});
      check(32'(busy_ok), 32'd1, {tag, " busy while running"});
      check(32'(busy), 32'd0, {tag, " busy at done"});
      check(result, exp, {tag, " result"});
      last_result = exp;
   endtask

   initial begin
      bit no_done;
      rst = 1'b1; start = 1'b0; divSel = 2'b00; data1 = '0; data2 = '0; flush = 1'b0;
      #1;
      check(32'(busy), 32'd0, "reset busy");
      check(32'(done), 32'd0, "reset done");
      check(result, 32'h0, "reset result");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed operations
      run_op(2'b01, 32'd100, 32'd7, "divu 100/7");
      run_op(2'b11, 32'd100, 32'd7, "remu 100/7");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div -7/2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem 7/-2");
      run_op(2'b00, 32'd5, 32'd0, "div 5/0");
      run_op(2'b11, 32'd5, 32'd0, "remu 5/0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem overflow");
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu big");
      @(posedge clk); #1;
      check(result, last_result, "result held after done");
      check(32'(done), 32'd0, "done is one pulse");

      // Flush and start together: flush wins
      start = 1'b1; flush = 1'b1; divSel = 2'b01; data1 = 32'd9; data2 = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check(32'(busy), 32'd0, "flush+start busy");
      check(32'(done), 32'd0, "flush+start done");

      // Flush in cycle 10 of DIVU 1000/3
      start = 1'b1; divSel = 2'b01; data1 = 32'd1000; data2 = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      check(32'(busy), 32'd1, "busy before flush");
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check(32'(busy), 32'd0, "flush busy");
      check(32'(done), 32'd0, "flush done");
      check(result, last_result, "flush result kept");
      no_done = 1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) no_done = 0;
      end
      check(32'(no_done), 32'd1, "no done after flush");
      run_op(2'b01, 32'd1000, 32'd3, "divu 1000/3");

      // Back-to-back: second start issued in the first DONE cycle
      @(posedge clk); #1;
      run_op(2'b01, 32'd50, 32'd5, "b2b divu 50/5");
      run_op(2'b11, 32'd50, 32'd7, "b2b remu 50/7");

      // Random sweep, biased toward the special and sign cases
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         logic [1:0]  s;
         s = 2'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: b = 32'h0 - 32'($urandom_range(1, 15));
            4: a = 32'($urandom_range(0, 100));
            default: ;
         endcase
         run_op(s, a, b, $sformatf("rand %0d sel=%0d %h/%h", i, s, a, b));
      end

      // Asynchronous reset in cycle 20 of a division
      @(posedge clk); #1;
      start = 1'b1; divSel = 2'b01; data1 = 32'd1000; data2 = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      check(32'(busy), 32'd1, "busy before reset");
      #2 rst = 1'b1;
      #1;
      check(32'(busy), 32'd0, "async reset busy");
      check(32'(done), 32'd0, "async reset done");
      check(result, 32'h0, "async reset result");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check(32'(busy), 32'd0, "idle after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide unit for the EX stage of the pipeline, beside the ALU. It executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm. It presents a start/busy/done handshake so the hazard unit can stall the pipeline while a division is in flight. Special cases complete in one cycle: divide-by-zero, and signed overflow for DIV/REM only.

## Interface
- No parameters; data width fixed at 32.
- clk    in   1   system clock; all state changes on its rising edge.
- rst    in   1   reset, asynchronous, active-high.
- start  in   1   request; sampled only in IDLE or DONE.
- divSel in   2   operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- data1  in   32  dividend (rs1 value).
- data2  in   32  divisor (rs2 value).
- flush  in   1   synchronous abort from pipeline flush.
- busy   out  1   high while a division is in progress; the pipeline stalls on it.
- done   out  1   one-cycle pulse; result valid in the same cycle.
- result out  32  quotient or remainder; held until the next completion.

## Operation
- States:
  - IDLE, PREP, CALC, DONE.
  - Reset value: IDLE, busy=0, done=0, result=0, internal count/registers 0.
- Operand capture:
  - On an accepted start, data1, data2 and divSel are registered.
  - Later changes on these inputs have no effect on the operation in flight.
- Signed vs unsigned:
  - Signed ops: DIV, REM. Unsigned ops: DIVU, REMU.
- Special cases, checked at start (IDLE/DONE → DONE directly, result loaded):
  - Divisor 0:
    - DIV/DIVU → 0xFFFFFFFF.
    - REM/REMU → data1.
  - Signed overflow, DIV/REM with data1=0x80000000 and data2=0xFFFFFFFF:
    - DIV → 0x80000000.
    - REM → 0.
- Normal path:
  - IDLE/DONE → PREP on start. PREP takes the absolute values of the operands (signed ops only) into a 32-bit divisor and a 64-bit remainder/quotient shift register. Records negQ = sign1 XOR sign2 and negR = sign1.
  - PREP → CALC, count=0.
  - Each CALC cycle:
    - Shift the 64-bit register left by 1.
    - Trial-subtract the divisor from the upper 33 bits.
    - If the result is non-negative, keep the difference and set quotient bit 0 to 1; otherwise restore.
    - count increments.
  - After 32 iterations (count=31 at the edge) → DONE. On that same edge, result is loaded with the quotient or remainder, two's-complement negated if negQ (DIV) / negR (REM) applies.
  - DONE lasts one cycle with done=1. Next state:
    - PREP, or DONE for a special case, if start=1.
    - Otherwise IDLE.
- Output decode:
  - busy = state is PREP or CALC.
  - done = state is DONE.
- start while PREP/CALC is ignored (pipeline is stalled; not a legal stimulus, but must not corrupt state).
- Flush:
  - Synchronous; any state → IDLE.
  - done is not pulsed for the aborted operation; result keeps its old value.
  - Flush and start in the same cycle: flush wins, start dropped.
- Reset mid-operation: immediate (asynchronous) return to reset values.
- Arithmetic:
  - abs(0x80000000) = 0x80000000 treated as unsigned 2^31 (correct because the datapath is unsigned 32-bit).
  - Negation is mod 2^32.

## Timing
- Cycle 0: start=1 accepted in IDLE.
- Normal operation:
  - Cycle 1: PREP, busy=1.
  - Cycles 2–33: CALC, busy=1.
  - Cycle 34: done=1, busy=0, result valid.
  - Latency start→done = 34 cycles.
- Special case: done=1 in cycle 1, busy never asserted; latency 1.
- Back-to-back: start in a DONE cycle makes the next operation begin with no idle gap. Result of the first operation is visible during its DONE cycle only for capture purposes; it is overwritten at the next completion.
- result changes only on the edge entering DONE, or on reset.

## Test plan
- DIVU data1=100, data2=7 → busy cycles 1–33, done cycle 34, result=14. Repeat with REMU → result=2.
- DIV data1=0xFFFFFFF9 (-7), data2=2 → result=0xFFFFFFFD (-3). REM same operands → 0xFFFFFFFF (-1). REM 7 / -2 → 1.
- DIV 5/0 → done in cycle 1, result=0xFFFFFFFF, busy never high. REMU 5/0 → result=5.
- DIV 0x80000000/0xFFFFFFFF → done cycle 1, result=0x80000000. REM same → 0. DIVU 0x80000000/0xFFFFFFFF → 34-cycle path, result=0.
- Flush at cycle 10 of DIVU 1000/3 → busy low cycle 11, no done pulse, result unchanged. New DIVU 1000/3 → 333. Assert rst in cycle 20 of a division → busy, done and result 0 immediately.
- Start DIVU 50/5 then start REMU 50/7 during the first DONE cycle → first done shows 10, second done 34 cycles later shows 1. Random signed/unsigned sweep checked against a reference model.
